// File: rtl/wu_fetch_mt.sv
// Multi-thread WU fetch: per-thread PCs and credit counters, round-robin issue
// onto one shared WU-memory read port, halt retirement and controller redirects.
module wu_fetch_mt #(
    parameter int NUM_THREADS  = 4,
    parameter int ADDR_WIDTH   = 24,
    parameter int FIFO_DEPTH   = 4,
    parameter int MGR_ID_WIDTH = 6,
    parameter int TID_WIDTH    = 2
) (
    input  logic                              clk,
    input  logic                              reset_poweron,
    input  logic [MGR_ID_WIDTH-1:0]           sys__mgr__mgrId,
    input  logic [NUM_THREADS-1:0]            mcntl__wuf__enable,
    input  logic [NUM_THREADS-1:0]            mcntl__wuf__start_valid,
    input  logic [NUM_THREADS*ADDR_WIDTH-1:0] mcntl__wuf__start_addr,
    input  logic [NUM_THREADS-1:0]            xxx__wuf__stall,
    input  logic [NUM_THREADS-1:0]            wud__wuf__credit_return,
    input  logic                              wud__wuf__halt,
    input  logic [TID_WIDTH-1:0]              wud__wuf__halt_tid,
    output logic                              wuf__wum__read,
    output logic [ADDR_WIDTH-1:0]             wuf__wum__addr,
    output logic [TID_WIDTH-1:0]              wuf__wum__tid,
    output logic [NUM_THREADS-1:0]            wuf__mcntl__busy,
    output logic [NUM_THREADS-1:0]            wuf__mcntl__done,
    output logic                              wuf__sys__error
);

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q [NUM_THREADS];
    state_e                state_d [NUM_THREADS];
    logic [ADDR_WIDTH-1:0] pc_q    [NUM_THREADS];
    logic [ADDR_WIDTH-1:0] pc_d    [NUM_THREADS];
    logic [CRED_W-1:0]     cred_q  [NUM_THREADS];
    logic [CRED_W-1:0]     cred_d  [NUM_THREADS];

    logic [TID_WIDTH-1:0]   rr_q, rr_d;
    logic                   read_q, read_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [TID_WIDTH-1:0]   tid_q, tid_d;
    logic [NUM_THREADS-1:0] done_q, done_d;
    logic                   err_q, err_d;

    logic [NUM_THREADS-1:0] start;
    logic [NUM_THREADS-1:0] elig;
    logic                   grant_vld;
    logic [TID_WIDTH-1:0]   grant_tid;

    // Manager id is carried for debug visibility only.
    logic unused_mgr_id;
    assign unused_mgr_id = ^sys__mgr__mgrId;

    // A redirecting thread sits out the cycle so no stale-PC read slips out.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            start[t] = mcntl__wuf__start_valid[t] & mcntl__wuf__enable[t];
            elig[t]  = (state_q[t] == ST_RUN) & mcntl__wuf__enable[t] &
                       ~xxx__wuf__stall[t] & (cred_q[t] != '0) & ~start[t];
        end
    end

    always_comb begin
        logic [TID_WIDTH:0] sum;
        logic [TID_WIDTH-1:0] idx;
        grant_vld = 1'b0;
        grant_tid = '0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            sum = {1'b0, rr_q} + (TID_WIDTH+1)'(i);
            if (sum >= (TID_WIDTH+1)'(NUM_THREADS)) begin
                sum = sum - (TID_WIDTH+1)'(NUM_THREADS);
            end
            idx = sum[TID_WIDTH-1:0];
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant_tid = idx;
            end
        end
    end

    always_comb begin
        logic issue;
        logic halt_hit;
        rr_d   = rr_q;
        read_d = grant_vld;
        addr_d = addr_q;
        tid_d  = tid_q;
        err_d  = err_q;
        done_d = '0;
        issue    = 1'b0;
        halt_hit = 1'b0;

        if (grant_vld) begin
            addr_d = pc_q[grant_tid];
            tid_d  = grant_tid;
            rr_d   = (grant_tid == TID_WIDTH'(NUM_THREADS - 1)) ? '0 : grant_tid + 1'b1;
        end

        for (int t = 0; t < NUM_THREADS; t++) begin
            state_d[t] = state_q[t];
            pc_d[t]    = pc_q[t];
            cred_d[t]  = cred_q[t];
            issue      = grant_vld && (grant_tid == TID_WIDTH'(t));
            halt_hit   = wud__wuf__halt && (wud__wuf__halt_tid == TID_WIDTH'(t)) &&
                         (state_q[t] == ST_RUN);

            // Start beats disable and halt; start and issue never coincide.
            if (start[t]) begin
                state_d[t] = ST_RUN;
                pc_d[t]    = mcntl__wuf__start_addr[t*ADDR_WIDTH +: ADDR_WIDTH];
            end else if (!mcntl__wuf__enable[t]) begin
                state_d[t] = ST_IDLE;
            end else if (halt_hit) begin
                state_d[t] = ST_DONE;
                done_d[t]  = 1'b1;
            end

            if (issue) begin
                pc_d[t] = pc_q[t] + 1'b1;
            end

            if (wud__wuf__credit_return[t] && !issue) begin
                if (cred_q[t] == CRED_W'(FIFO_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    cred_d[t] = cred_q[t] + 1'b1;
                end
            end else if (!wud__wuf__credit_return[t] && issue) begin
                cred_d[t] = cred_q[t] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= ST_IDLE;
                pc_q[t]    <= '0;
                cred_q[t]  <= CRED_W'(FIFO_DEPTH);
            end
            rr_q   <= '0;
            read_q <= 1'b0;
            addr_q <= '0;
            tid_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cred_q  <= cred_d;
            rr_q    <= rr_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            tid_q   <= tid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            wuf__mcntl__busy[t] = (state_q[t] == ST_RUN);
        end
    end

    assign wuf__wum__read   = read_q;
    assign wuf__wum__addr   = addr_q;
    assign wuf__wum__tid    = tid_q;
    assign wuf__mcntl__done = done_q;
    assign wuf__sys__error  = err_q;

endmodule
